// File: rtl/ceu_route_sequencer.sv
// Route-word sequencer for the CEU data switch: stages control-plane route writes
// per region and commits them only between packets, gating the stream for one cycle.

module ceu_route_lane #(
    parameter int ID         = 0,
    parameter int ROUTE_BITS = 14,
    parameter int CNT_BITS   = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  wr,
    input  logic [ROUTE_BITS-1:0] wr_route,
    input  logic                  tvalid,
    input  logic                  tready,
    input  logic                  tlast,
    input  logic                  cnt_clr,
    output logic                  gate,
    output logic [ROUTE_BITS-1:0] route,
    output logic                  pend,
    output logic [CNT_BITS-1:0]   cnt
);
    typedef enum logic [1:0] {IDLE, BUSY, COMMIT} state_t;

    localparam logic [ROUTE_BITS-1:0] RST_ROUTE = ROUTE_BITS'({4'(ID), 10'h3FC});

    state_t                state, state_nxt;
    logic [ROUTE_BITS-1:0] stage;
    logic                  beat;

    assign gate = (state != COMMIT);
    assign beat = tvalid && tready && gate;

    // A write landing this cycle counts as pending so an idle region commits next cycle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (beat && !tlast)
                    state_nxt = BUSY;
                else if (!beat && (pend || wr))
                    state_nxt = COMMIT;
            end
            BUSY: begin
                if (beat && tlast)
                    state_nxt = IDLE;
            end
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
            stage <= '0;
            pend  <= 1'b0;
            route <= RST_ROUTE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (wr) begin
                stage <= wr_route;
                pend  <= 1'b1;
            end else if (state == COMMIT) begin
                pend  <= 1'b0;
            end
            if (state == COMMIT)
                route <= stage;
            if (cnt_clr)
                cnt <= '0;
            else if (beat && tlast && (cnt != '1))
                cnt <= cnt + 1'b1;
        end
    end
endmodule

module ceu_route_sequencer #(
    parameter int N_ID       = 6,
    parameter int ROUTE_BITS = 14,
    parameter int CNT_BITS   = 16
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic                                cfg_valid,
    output logic                                cfg_ready,
    input  logic [3:0]                          cfg_region,
    input  logic [ROUTE_BITS-1:0]               cfg_route,
    input  logic [N_ID-1:0]                     mon_tvalid,
    input  logic [N_ID-1:0]                     mon_tready,
    input  logic [N_ID-1:0]                     mon_tlast,
    output logic [N_ID-1:0]                     gate,
    output logic [N_ID-1:0][ROUTE_BITS-1:0]     route_out,
    output logic [N_ID-1:0]                     pend,
    output logic [N_ID-1:0][CNT_BITS-1:0]       pkt_cnt,
    input  logic                                cnt_clr,
    output logic [1:0]                          cfg_err,
    input  logic                                err_clr
);
    logic [N_ID-1:0] wr_sel;
    logic            bad_region, bad_dest, acc;

    always_comb begin
        bad_region = int'(cfg_region) >= N_ID;
        bad_dest   = int'(cfg_route[ROUTE_BITS-1 -: 4]) >= 2 * N_ID;
        cfg_ready  = 1'b1;
        for (int i = 0; i < N_ID; i++)
            if (cfg_region == 4'(i))
                cfg_ready = !pend[i];
        acc = cfg_valid && cfg_ready;
        for (int i = 0; i < N_ID; i++)
            wr_sel[i] = acc && !bad_region && !bad_dest && (cfg_region == 4'(i));
    end

    // New errors OR in after the clear so a same-cycle error survives err_clr.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            cfg_err <= 2'b00;
        else
            cfg_err <= (err_clr ? 2'b00 : cfg_err)
                     | {acc && !bad_region && bad_dest, acc && bad_region};
    end

    for (genvar g = 0; g < N_ID; g++) begin : g_lane
        ceu_route_lane #(
            .ID         (g),
            .ROUTE_BITS (ROUTE_BITS),
            .CNT_BITS   (CNT_BITS)
        ) u_lane (
            .aclk     (aclk),
            .aresetn  (aresetn),
            .wr       (wr_sel[g]),
            .wr_route (cfg_route),
            .tvalid   (mon_tvalid[g]),
            .tready   (mon_tready[g]),
            .tlast    (mon_tlast[g]),
            .cnt_clr  (cnt_clr),
            .gate     (gate[g]),
            .route    (route_out[g]),
            .pend     (pend[g]),
            .cnt      (pkt_cnt[g])
        );
    end
endmodule

// File: tb/tb_ceu_route_sequencer.sv
// Directed bench for ceu_route_sequencer with hand-computed route/commit/count expectations.

module tb_ceu_route_sequencer;
    localparam int N = 6;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [3:0]        cfg_region = '0;
    logic [13:0]       cfg_route = '0;
    logic [N-1:0]      mon_tvalid = '0, mon_tready = '0, mon_tlast = '0;
    logic [N-1:0]      gate, pend;
    logic [N-1:0][13:0] route_out;
    logic [N-1:0][15:0] pkt_cnt;
    logic              cnt_clr = 1'b0, err_clr = 1'b0;
    logic [1:0]        cfg_err;

    int checks = 0;
    int errors = 0;

    ceu_route_sequencer #(.N_ID(N), .ROUTE_BITS(14), .CNT_BITS(16)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_region (cfg_region),
        .cfg_route  (cfg_route),
        .mon_tvalid (mon_tvalid),
        .mon_tready (mon_tready),
        .mon_tlast  (mon_tlast),
        .gate       (gate),
        .route_out  (route_out),
        .pend       (pend),
        .pkt_cnt    (pkt_cnt),
        .cnt_clr    (cnt_clr),
        .cfg_err    (cfg_err),
        .err_clr    (err_clr)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #2;
    endtask

    task automatic wr(input logic [3:0] r, input logic [13:0] rt);
        cfg_valid  = 1'b1;
        cfg_region = r;
        cfg_route  = rt;
    endtask

    initial begin
        bit found;
        repeat (3) step();
        aresetn = 1'b1;
        step();

        // reset state
        chk("rst_route2", route_out[2], 14'b00101111111100);
        chk("rst_gate", gate, 6'h3F);
        chk("rst_cnt", pkt_cnt, '0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_pend", pend, 0);
        chk("rst_err", cfg_err, 0);

        // idle region 1: write cycle 0, commit cycle 1, new route cycle 2
        wr(4'd1, 14'h2BFC);
        #1 chk("idle_ready", cfg_ready, 1);
        step();
        cfg_valid = 1'b0;
        chk("idle_pend_c1", pend[1], 1);
        chk("idle_gate_c1", gate[1], 0);
        chk("idle_route_c1", route_out[1], 14'h07FC);
        step();
        chk("idle_route_c2", route_out[1], 14'h2BFC);
        chk("idle_gate_c2", gate[1], 1);
        chk("idle_pend_c2", pend[1], 0);

        // region 0: 5-beat packet, write after 3 beats
        mon_tvalid[0] = 1'b1; mon_tready[0] = 1'b1; mon_tlast[0] = 1'b0;
        repeat (3) step();
        wr(4'd0, 14'h1BFC);
        step();
        cfg_valid = 1'b0;
        mon_tlast[0] = 1'b1;
        chk("mid_pend", pend[0], 1);
        chk("mid_gate", gate[0], 1);
        chk("mid_route_b5", route_out[0], 14'h03FC);
        step();
        mon_tvalid[0] = 1'b0; mon_tlast[0] = 1'b0;
        chk("mid_route_after_tlast", route_out[0], 14'h03FC);
        chk("mid_cnt", pkt_cnt[0], 1);
        // second write held off while the first is pending
        wr(4'd0, 14'h17FC);
        #1 chk("second_ready_blocked", cfg_ready, 0);
        found = 1'b0;
        for (int k = 0; k < 5 && !found; k++) begin
            if (gate[0] == 1'b0) found = 1'b1;
            else step();
        end
        chk("mid_commit_seen", found, 1);
        chk("commit_ready_blocked", cfg_ready, 0);
        step();
        chk("mid_route_new", route_out[0], 14'h1BFC);
        chk("mid_gate_back", gate[0], 1);
        chk("second_ready_open", cfg_ready, 1);
        step();
        cfg_valid = 1'b0;
        chk("second_pend", pend[0], 1);
        chk("second_commit_gate", gate[0], 0);
        step();
        chk("second_route", route_out[0], 14'h17FC);

        // configuration errors
        wr(4'd7, 14'h07FC);
        step();
        cfg_valid = 1'b0;
        chk("err_region", cfg_err, 2'b01);
        chk("err_region_pend", pend, 0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("err_clr1", cfg_err, 0);
        wr(4'd2, 14'h33FC);
        step();
        cfg_valid = 1'b0;
        chk("err_dest", cfg_err, 2'b10);
        chk("err_dest_pend", pend, 0);
        wr(4'd9, 14'h07FC);
        err_clr = 1'b1;
        step();
        cfg_valid = 1'b0;
        chk("err_new_beats_clr", cfg_err, 2'b01);
        step();
        err_clr = 1'b0;
        chk("err_clr2", cfg_err, 0);

        // back-to-back single-beat packets defer the commit on region 5
        mon_tvalid[5] = 1'b1; mon_tready[5] = 1'b1; mon_tlast[5] = 1'b1;
        step();
        wr(4'd5, 14'h07FC);
        step();
        cfg_valid = 1'b0;
        chk("b2b_pend", pend[5], 1);
        chk("b2b_gate", gate[5], 1);
        repeat (2) step();
        chk("b2b_gate_held", gate[5], 1);
        chk("b2b_route_held", route_out[5], 14'h17FC);
        chk("b2b_cnt", pkt_cnt[5], 4);
        mon_tvalid[5] = 1'b0;
        step();
        chk("b2b_commit_gate", gate[5], 0);
        step();
        chk("b2b_route_new", route_out[5], 14'h07FC);

        // counter saturation, then clear beating a simultaneous increment
        mon_tvalid[3] = 1'b1; mon_tready[3] = 1'b1; mon_tlast[3] = 1'b1;
        repeat (65540) step();
        chk("cnt_sat", pkt_cnt[3], 16'hFFFF);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("cnt_clr3", pkt_cnt[3], 0);
        chk("cnt_clr0", pkt_cnt[0], 0);
        step();
        mon_tvalid[3] = 1'b0;
        chk("cnt_after_clr", pkt_cnt[3], 1);

        // reset during BUSY with a pending route on region 4
        mon_tvalid[4] = 1'b1; mon_tready[4] = 1'b1; mon_tlast[4] = 1'b0;
        step();
        wr(4'd4, 14'h1BFC);
        step();
        cfg_valid = 1'b0;
        mon_tvalid[4] = 1'b0;
        chk("rst_mid_pend_pre", pend[4], 1);
        #2 aresetn = 1'b0;
        #1;
        chk("rst_mid_pend", pend, 0);
        chk("rst_mid_route0", route_out[0], 14'h03FC);
        chk("rst_mid_route1", route_out[1], 14'h07FC);
        chk("rst_mid_route4", route_out[4], 14'h13FC);
        chk("rst_mid_gate", gate, 6'h3F);
        step();
        aresetn = 1'b1;
        mon_tvalid[4] = 1'b1; mon_tlast[4] = 1'b1;
        step();
        mon_tvalid[4] = 1'b0; mon_tlast[4] = 1'b0;
        chk("rst_idle_cnt", pkt_cnt[4], 1);
        step();
        chk("rst_idle_gate", gate[4], 1);
        chk("rst_idle_route", route_out[4], 14'h13FC);
        chk("rst_idle_pend", pend, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
